// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, multi-cycle FSM states, iteration count.
// Latency/backpressure: none (types and constants only).
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_LUI  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_MUL  = 4'd11,
        ALU_DIVU = 4'd12,
        ALU_REMU = 4'd13
    } aluc_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    function automatic logic is_mdu_op(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIVU) || (code == ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) and unsigned divide (restoring), one bit per cycle.
// Latency: ITERATIONS cycles after start; done strobes during the final step; abort drops the op.
module mdu_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    // hi: product accumulator / partial remainder; lo: multiplier / quotient; dv: multiplicand / divisor
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dv;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted - {1'b0, dv};
        done    = running && (cnt == CNT_W'(ITERATIONS - 1));
        case (op_q)
            ALU_MUL:  result = hi;
            ALU_DIVU: result = lo;
            ALU_REMU: result = hi;
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            op_q    <= '0;
            hi      <= '0;
            lo      <= '0;
            dv      <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            op_q    <= op;
            hi      <= '0;
            lo      <= (op == ALU_MUL) ? b : a;
            dv      <= (op == ALU_MUL) ? a : b;
        end else if (abort) begin
            running <= 1'b0;
        end else if (running) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
            if (op_q == ALU_MUL) begin
                if (lo[0]) begin
                    hi <= hi + dv;
                end
                dv <= dv << 1;
                lo <= lo >> 1;
            end else if (!trial[WIDTH]) begin
                // a zero divisor always "fits", giving all-ones quotient and remainder = dividend
                hi <= trial[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi <= shifted[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus FSM sequencing the iterative mul/div unit.
// Latency 0 for ALU ops, 33 cycles for MUL/DIVU/REMU; e_busy stalls upstream until the result is ready.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_aluc,
    input  logic [WIDTH-1:0] e_alua,
    input  logic [WIDTH-1:0] e_alub,
    input  logic             e_hold,
    input  logic             e_flush,
    output logic [WIDTH-1:0] e_alu_out,
    output logic             e_z,
    output logic             e_busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state;
    logic             start;
    logic             abort;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_result;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   sh;

    assign sh    = e_alua[SHW-1:0];
    // reset gates start so a held multi-cycle op cannot raise e_busy while reset is asserted
    assign start = (state == ST_IDLE) && !reset && e_valid && is_mdu_op(e_aluc) && !e_flush;
    assign abort = (state != ST_IDLE) && e_flush;

    always_comb begin
        alu_res = '0;
        case (e_aluc)
            ALU_ADD:  alu_res = e_alua + e_alub;
            ALU_SUB:  alu_res = e_alua - e_alub;
            ALU_AND:  alu_res = e_alua & e_alub;
            ALU_OR:   alu_res = e_alua | e_alub;
            ALU_XOR:  alu_res = e_alua ^ e_alub;
            ALU_LUI:  alu_res = e_alub << 16;
            ALU_SLL:  alu_res = e_alub << sh;
            ALU_SRL:  alu_res = e_alub >> sh;
            ALU_SRA:  alu_res = $signed(e_alub) >>> sh;
            ALU_SLT:  alu_res[0] = $signed(e_alua) < $signed(e_alub);
            ALU_SLTU: alu_res[0] = e_alua < e_alub;
            default:  alu_res = '0;
        endcase
    end

    assign e_alu_out = (state == ST_DONE) ? mdu_result : alu_res;
    assign e_z       = (e_alu_out == '0);
    assign e_busy    = start || (state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_BUSY;
                ST_BUSY: begin
                    if (e_flush)       state <= ST_IDLE;
                    else if (mdu_done) state <= ST_DONE;
                end
                ST_DONE: if (e_flush || !e_hold) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .op     (e_aluc),
        .a      (e_alua),
        .b      (e_alub),
        .result (mdu_result),
        .done   (mdu_done)
    );

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: opcode vector table through a result scoreboard, plus flush/hold/reset sequences.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_aluc;
    logic [31:0] e_alua;
    logic [31:0] e_alub;
    logic        e_hold;
    logic        e_flush;
    logic [31:0] e_alu_out;
    logic        e_z;
    logic        e_busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_aluc    (e_aluc),
        .e_alua    (e_alua),
        .e_alub    (e_alub),
        .e_hold    (e_hold),
        .e_flush   (e_flush),
        .e_alu_out (e_alu_out),
        .e_z       (e_z),
        .e_busy    (e_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hold);
        @(posedge clk); #1;
        e_valid = 1'b1; e_aluc = op; e_alua = a; e_alub = b; e_hold = hold; e_flush = 1'b0;
    endtask

    task automatic bubble(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        e_valid = 1'b0; e_aluc = 4'd0; e_alua = a; e_alub = b; e_hold = 1'b0; e_flush = 1'b0;
    endtask

    // Drives one op, counts e_busy cycles, then checks the result against the scoreboard.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic hold);
        int          busy_cycles;
        logic [31:0] e;
        logic        mdu;
        mdu = (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
        drive(op, a, b, hold);
        exp_q.push_back(exp);
        busy_cycles = 0;
        @(negedge clk);
        while (e_busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check($sformatf("busy_cycles op%0d", op), 32'(busy_cycles), mdu ? 32'd33 : 32'd0);
        check($sformatf("result op%0d a=%08h b=%08h", op, a, b), e_alu_out, e);
        check($sformatf("zero op%0d", op), {31'd0, e_z}, {31'd0, e == 32'd0});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] p;

        vecs.push_back(vec_t'{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back(vec_t'{4'd0,  32'h00000005, 32'h00000007, 32'h0000000C});
        vecs.push_back(vec_t'{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE});
        vecs.push_back(vec_t'{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
        vecs.push_back(vec_t'{4'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0});
        vecs.push_back(vec_t'{4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555});
        vecs.push_back(vec_t'{4'd5,  32'h0000DEAD, 32'h00001234, 32'h12340000});
        vecs.push_back(vec_t'{4'd6,  32'h00000004, 32'h00000001, 32'h00000010});
        vecs.push_back(vec_t'{4'd6,  32'h00000024, 32'h00000003, 32'h00000030});
        vecs.push_back(vec_t'{4'd7,  32'h00000004, 32'h80000000, 32'h08000000});
        vecs.push_back(vec_t'{4'd8,  32'h00000004, 32'h80000000, 32'hF8000000});
        vecs.push_back(vec_t'{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001});
        vecs.push_back(vec_t'{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back(vec_t'{4'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back(vec_t'{4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000001});
        vecs.push_back(vec_t'{4'd14, 32'h00000005, 32'h00000006, 32'h00000000});
        vecs.push_back(vec_t'{4'd15, 32'h00000005, 32'h00000006, 32'h00000000});
        vecs.push_back(vec_t'{4'd11, 32'h00012345, 32'h00000100, 32'h01234500});
        vecs.push_back(vec_t'{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
        vecs.push_back(vec_t'{4'd12, 32'd100,      32'd7,        32'd14});
        vecs.push_back(vec_t'{4'd13, 32'd100,      32'd7,        32'd2});
        vecs.push_back(vec_t'{4'd12, 32'd5,        32'd0,        32'hFFFFFFFF});
        vecs.push_back(vec_t'{4'd13, 32'd5,        32'd0,        32'd5});

        // Reset held with a valid MUL in E: no busy, IDLE ALU path shows 0 for opcode 11.
        reset = 1'b1; e_valid = 1'b1; e_aluc = 4'd11; e_alua = 32'd3; e_alub = 32'd4;
        e_hold = 1'b0; e_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, e_busy}, 32'd0);
        check("reset out", e_alu_out, 32'd0);
        check("reset z", {31'd0, e_z}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; e_valid = 1'b0; e_aluc = 4'd0;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 100000);
            p  = ra * rb;
            run_op(4'd11, ra, rb, p, 1'b0);
            run_op(4'd12, ra, rb, ra / rb, 1'b0);
            run_op(4'd13, ra, rb, ra % rb, 1'b0);
        end

        // Flush in IDLE blocks the start, both in that cycle and the next.
        drive(4'd11, 32'd3, 32'd4, 1'b0);
        e_flush = 1'b1;
        @(negedge clk);
        check("idle flush busy", {31'd0, e_busy}, 32'd0);
        bubble(32'd0, 32'd0);
        @(negedge clk);
        check("idle flush no start", {31'd0, e_busy}, 32'd0);

        // MUL flushed at cycle 10; ADD in cycle 11 completes combinationally.
        drive(4'd11, 32'h00012345, 32'h00000100, 1'b0);
        repeat (10) @(posedge clk);
        #1 e_flush = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        e_flush = 1'b0; e_aluc = 4'd0; e_alua = 32'd3; e_alub = 32'd4;
        @(negedge clk);
        check("flush busy c11", {31'd0, e_busy}, 32'd0);
        check("flush add c11", e_alu_out, 32'd7);
        @(negedge clk);
        check("flush busy c12", {31'd0, e_busy}, 32'd0);

        // DIVU with hold: result stable for 4 cycles, no restart afterwards.
        run_op(4'd12, 32'd100, 32'd7, 32'd14, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("hold result", e_alu_out, 32'd14);
            check("hold busy", {31'd0, e_busy}, 32'd0);
        end
        @(posedge clk); #1 e_hold = 1'b0;
        @(negedge clk);
        check("hold release result", e_alu_out, 32'd14);
        check("hold release busy", {31'd0, e_busy}, 32'd0);
        bubble(32'd9, 32'd1);
        @(negedge clk);
        check("bubble out", e_alu_out, 32'd10);
        check("bubble busy", {31'd0, e_busy}, 32'd0);

        // Flush while in DONE under hold returns to IDLE.
        run_op(4'd13, 32'd100, 32'd7, 32'd2, 1'b1);
        @(posedge clk); #1 e_flush = 1'b1;
        @(posedge clk); #1;
        e_flush = 1'b0; e_valid = 1'b0; e_aluc = 4'd0; e_alua = 32'd2; e_alub = 32'd2;
        @(negedge clk);
        check("done flush out", e_alu_out, 32'd4);
        check("done flush busy", {31'd0, e_busy}, 32'd0);

        // Reset at BUSY cycle 5 abandons the divide.
        drive(4'd12, 32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset mid busy", {31'd0, e_busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; e_aluc = 4'd0; e_alua = 32'd1; e_alub = 32'd1;
        @(negedge clk);
        check("post reset busy", {31'd0, e_busy}, 32'd0);
        check("post reset add", e_alu_out, 32'd2);

        run_op(4'd11, 32'd6, 32'd7, 32'd42, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
